logicnet_pipe_ctrl: RTL and testbench

LOGICNET_PIPE_CTRL -- requirements
Module: logicnet_pipe_ctrl

---
 rtl/logicnet_pipe_ctrl.sv | 150 +++++++++++++++
 tb/tb_logicnet_pipe_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/logicnet_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// logicnet_pipe_ctrl
// Valid/ready sequencer for a chain of NUM_LAYERS registered LUT-layer stages.
// It tracks which layer registers hold valid data and generates per-layer load
// enables. Backpressure ripples back from the consumer, bubbles compact toward
// the output, and a synchronous flush empties the whole chain.
//
// Parameters
//   NUM_LAYERS : number of layer stages (1..16)
//   CNT_W      : width of the optional performance counters
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : input vector presented to layer 0
//   in_ready   : layer 0 accepts this cycle (combinational)
//   out_valid  : final layer holds a valid result
//   out_ready  : consumer takes the result this cycle
//   flush      : synchronous invalidate of every stage
//   stage_en   : per-layer register load enable (combinational)
//   stage_vld  : per-layer valid flags
//   occupancy  : registered count of valid layers
//
// Optional feature (macro LOGICNET_PIPE_PERF_CNT_EN):
//   acc_cnt    : accepted vectors
//   out_cnt    : delivered results
//   stall_cnt  : cycles with a result held by a stalled consumer
// -----------------------------------------------------------------------------
module logicnet_pipe_ctrl #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  output logic [NUM_LAYERS-1:0] stage_en,
  output logic [NUM_LAYERS-1:0] stage_vld,
  output logic [4:0]            occupancy
`ifdef LOGICNET_PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      acc_cnt,
  output logic [CNT_W-1:0]      out_cnt,
  output logic [CNT_W-1:0]      stall_cnt
`endif
);

  localparam int unsigned LAST  = NUM_LAYERS - 1;
  localparam int unsigned OCC_W = 5;

  logic [NUM_LAYERS-1:0] v_q;
  logic [NUM_LAYERS-1:0] v_d;
  logic [NUM_LAYERS-1:0] ready;
  logic [OCC_W-1:0]      occ_q;
  logic [OCC_W-1:0]      occ_d;

  // Backpressure chain, built with a running term so no bit reads its own vector
  always_comb begin : ready_chain
    logic r;
    ready = '0;
    r     = out_ready;
    for (int s = int'(LAST); s >= 0; s--) begin
      r        = !v_q[s] | r;
      ready[s] = r;
    end
  end

  // Load enables; flush and reset suppress every handshake
  always_comb begin : enables
    in_ready    = ready[0] & !flush & rst;
    stage_en    = '0;
    stage_en[0] = in_valid & in_ready;
    for (int s = 1; s < int'(NUM_LAYERS); s++) begin
      stage_en[s] = v_q[s-1] & ready[s] & !flush & rst;
    end
  end

  // Next valid vector and its popcount
  always_comb begin : next_state
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else begin
      for (int s = 0; s < int'(NUM_LAYERS); s++) begin
        if (stage_en[s]) begin
          v_d[s] = 1'b1;
        end else if (ready[s]) begin
          // Contents moved on (or were consumed) with nothing replacing them
          v_d[s] = 1'b0;
        end
      end
    end
    occ_d = '0;
    for (int s = 0; s < int'(NUM_LAYERS); s++) begin
      occ_d = occ_d + OCC_W'(v_d[s]);
    end
  end

  // Valid flags and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  assign stage_vld = v_q;
  assign out_valid = v_q[LAST];
  assign occupancy = occ_q;

`ifdef LOGICNET_PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // Wrapping performance counters, cleared by flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (flush) begin
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (stage_en[0]) begin
        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
      end
      if (out_valid && out_ready) begin
        out_cnt_q <= out_cnt_q + CNT_W'(1);
      end
      if (out_valid && !out_ready) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign acc_cnt   = acc_cnt_q;
  assign out_cnt   = out_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_logicnet_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_logicnet_pipe_ctrl
// Directed bench for logicnet_pipe_ctrl with NUM_LAYERS=4: reset, streaming
// latency/throughput, fill under backpressure, bubble compaction, flush,
// mid-stream reset and, when LOGICNET_PIPE_PERF_CNT_EN is defined, counters.
// -----------------------------------------------------------------------------
module tb_logicnet_pipe_ctrl;

  localparam int unsigned NL    = 4;
  localparam int unsigned CNT_W = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          flush;
  logic [NL-1:0] stage_en;
  logic [NL-1:0] stage_vld;
  logic [4:0]    occupancy;
`ifdef LOGICNET_PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] stall_cnt;
`endif

  int n_tests;
  int n_fail;

  logicnet_pipe_ctrl #(
    .NUM_LAYERS (NL),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .stage_en  (stage_en),
    .stage_vld (stage_vld),
    .occupancy (occupancy)
`ifdef LOGICNET_PIPE_PERF_CNT_EN
    ,
    .acc_cnt   (acc_cnt),
    .out_cnt   (out_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and checks happen well away from edges
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    flush     = 1'b0;

    // Reset state, with in_valid high to show nothing leaks through
    #2;
    check_eq("rst_in_ready",  32'(in_ready),  32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_stage_en",  32'(stage_en),  32'd0);
    check_eq("rst_stage_vld", 32'(stage_vld), 32'd0);
    check_eq("rst_occupancy", 32'(occupancy), 32'd0);
    step();
    step();

    // Stream with out_ready high: out_valid from edge 4, occupancy saturates at 4
    rst = 1'b1;
    #1;
    check_eq("rel_in_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      step();
      check_eq($sformatf("stream_out_valid_%0d", k), 32'(out_valid), (k >= 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("stream_occ_%0d", k), 32'(occupancy), (k >= 4) ? 32'd4 : 32'(k));
      check_eq($sformatf("stream_in_ready_%0d", k), 32'(in_ready), 32'd1);
    end
    check_eq("stream_stage_en", 32'(stage_en), 32'hf);

    // Flush to empty
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    check_eq("flush_in_ready", 32'(in_ready), 32'd0);
    check_eq("flush_stage_en", 32'(stage_en), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check_eq("flush_stage_vld", 32'(stage_vld), 32'd0);
    check_eq("flush_occ",       32'(occupancy), 32'd0);

    // Fill under backpressure: pushes straight through, then stops full
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq($sformatf("fill_vld_%0d", k), 32'(stage_vld), 32'((1 << k) - 1));
    end
    #1;
    check_eq("full_in_ready", 32'(in_ready),  32'd0);
    check_eq("full_stage_en", 32'(stage_en),  32'd0);
    check_eq("full_occ",      32'(occupancy), 32'd4);
    check_eq("full_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    #1;
    check_eq("pop_stage_en", 32'(stage_en), 32'hf);
    check_eq("pop_in_ready", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b0;
    #1;
    check_eq("pop_stage_vld", 32'(stage_vld), 32'hf);
    check_eq("pop_occ",       32'(occupancy), 32'd4);

    // Reset mid-stream while full: outputs clear before the next edge
    rst = 1'b0;
    #1;
    check_eq("midrst_stage_vld", 32'(stage_vld), 32'd0);
    check_eq("midrst_occ",       32'(occupancy), 32'd0);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_in_ready",  32'(in_ready),  32'd0);
    check_eq("midrst_stage_en",  32'(stage_en),  32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    step();
    check_eq("postrst_idle_vld", 32'(stage_vld), 32'd0);

    // Two vectors separated by two idle cycles compact at the output end
    in_valid = 1'b1;
    step();
    check_eq("sep_first", 32'(stage_vld), 32'b0001);
    in_valid = 1'b0;
    step();
    step();
    in_valid = 1'b1;
    step();
    check_eq("sep_second", 32'(stage_vld), 32'b1001);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check_eq("compact_vld", 32'(stage_vld), 32'b1100);
    check_eq("compact_occ", 32'(occupancy), 32'd2);

    // Third vector lands in stage 0, then flush with occupancy 3
    in_valid = 1'b1;
    step();
    check_eq("occ3_vld", 32'(stage_vld), 32'b1101);
    check_eq("occ3_occ", 32'(occupancy), 32'd3);
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    check_eq("occ3_flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    #1;
    check_eq("occ3_post_vld",       32'(stage_vld), 32'd0);
    check_eq("occ3_post_out_valid", 32'(out_valid), 32'd0);
    check_eq("occ3_post_in_ready",  32'(in_ready),  32'd1);

    // Flush coinciding with a consumer take still empties the pipe
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    flush = 1'b1;
    #1;
    check_eq("fl_take_out_valid", 32'(out_valid), 32'd1);
    check_eq("fl_take_stage_en",  32'(stage_en),  32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("fl_take_vld", 32'(stage_vld), 32'd0);

`ifdef LOGICNET_PIPE_PERF_CNT_EN
    // Counters were cleared by the flush above
    check_eq("cnt_acc_clr",   32'(acc_cnt),   32'd0);
    check_eq("cnt_out_clr",   32'(out_cnt),   32'd0);
    check_eq("cnt_stall_clr", 32'(stall_cnt), 32'd0);
    // 6 accepts (2 outputs along the way), 3 stalls, then 3 more outputs
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) step();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    out_ready = 1'b0;
    #1;
    check_eq("cnt_acc",   32'(acc_cnt),   32'd6);
    check_eq("cnt_out",   32'(out_cnt),   32'd5);
    check_eq("cnt_stall", 32'(stall_cnt), 32'd3);
    check_eq("cnt_vld",   32'(stage_vld), 32'b1000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    check_eq("cnt_acc_flush", 32'(acc_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
